// File: rtl/dcf77_sync_ctrl_pkg.sv
// Shared types for the DCF77 frame qualifier: BCD digits, the decoded
// time record, the lock state machine encoding and the holdover tick rate.
package dcf77_sync_ctrl_pkg;

    typedef logic [3:0] bcd_t;
    // Two-digit BCD field: [1] is the tens digit, [0] the units digit.
    typedef bcd_t [1:0] bcd2_t;

    typedef struct packed {
        bcd2_t      year;
        bcd2_t      month;
        bcd2_t      day;
        logic [2:0] dow;
        bcd2_t      hour;
        bcd2_t      minute;
    } dcf77_time_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        CANDIDATE,
        LOCKED,
        HOLDOVER
    } sync_state_t;

    // 10 ms ticks per minute.
    localparam int unsigned TICKS_PER_MINUTE = 6000;

    // Power-on time: 00-01-01, weekday 1, 00:00.
    localparam dcf77_time_t RESET_TIME = '{
        year:   8'h00,
        month:  8'h01,
        day:    8'h01,
        dow:    3'd1,
        hour:   8'h00,
        minute: 8'h00
    };

    // Binary value of a two-digit BCD field; only meaningful when both digits are <= 9.
    function automatic logic [6:0] bcd2bin(input bcd2_t v);
        return 7'(v[1]) * 7'd10 + 7'(v[0]);
    endfunction

    function automatic logic bcd2_digits_ok(input bcd2_t v);
        return (v[1] <= 4'd9) && (v[0] <= 4'd9);
    endfunction

endpackage

// File: rtl/dcf77_frame_check.sv
// Combinational frame qualifier: range check of the incoming frame and the
// +1 minute succession check against the previously stored frame.
module dcf77_frame_check
    import dcf77_sync_ctrl_pkg::*;
(
    input  dcf77_time_t cur,
    input  dcf77_time_t prev,
    output logic        frame_ok,
    output logic        frame_next
);

    logic [6:0] cur_min, cur_hour, cur_day, cur_month;
    logic [6:0] prev_min, prev_hour;
    logic       digits_ok;
    logic       date_same;
    logic       min_wrap;

    assign cur_min   = bcd2bin(cur.minute);
    assign cur_hour  = bcd2bin(cur.hour);
    assign cur_day   = bcd2bin(cur.day);
    assign cur_month = bcd2bin(cur.month);
    assign prev_min  = bcd2bin(prev.minute);
    assign prev_hour = bcd2bin(prev.hour);

    assign digits_ok = bcd2_digits_ok(cur.year)  && bcd2_digits_ok(cur.month) &&
                       bcd2_digits_ok(cur.day)   && bcd2_digits_ok(cur.hour)  &&
                       bcd2_digits_ok(cur.minute);

    assign frame_ok = digits_ok &&
                      (cur_min   <= 7'd59) &&
                      (cur_hour  <= 7'd23) &&
                      (cur_day   >= 7'd1) && (cur_day   <= 7'd31) &&
                      (cur_month >= 7'd1) && (cur_month <= 7'd12) &&
                      (cur.dow != 3'd0);

    assign date_same = (cur.year == prev.year) && (cur.month == prev.month) &&
                       (cur.day == prev.day)   && (cur.dow == prev.dow);
    assign min_wrap  = (prev_min == 7'd59);

    // Succession rules; across midnight the date is trusted and not compared.
    always_comb begin
        // NOTE: assign a default first so no path leaves frame_next unassigned (would infer a latch).
        frame_next = 1'b0;
        if (!min_wrap) begin
            frame_next = (cur_min == prev_min + 7'd1) && (cur.hour == prev.hour) && date_same;
        end else if (prev_hour != 7'd23) begin
            frame_next = (cur_min == 7'd0) && (cur_hour == prev_hour + 7'd1) && date_same;
        end else begin
            frame_next = (cur_min == 7'd0) && (cur_hour == 7'd0);
        end
    end

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// DCF77 sync qualifier: passes a decoded frame to the clock only after
// CONFIRM_FRAMES consecutive consistent frames, then tracks lock/holdover.
// Optional build macro DCF77_SYNC_STATS_EN builds the saturating reject
// counter; without it reject_count is tied to zero.
module dcf77_sync_ctrl
    import dcf77_sync_ctrl_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned HOLDOVER_MIN   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       frame_valid,
    input  bcd2_t      frame_year,
    input  bcd2_t      frame_month,
    input  bcd2_t      frame_day,
    input  logic [2:0] frame_day_of_week,
    input  bcd2_t      frame_hour,
    input  bcd2_t      frame_minute,
    output logic       dcf77_sync,
    output bcd2_t      dcf77_year,
    output bcd2_t      dcf77_month,
    output bcd2_t      dcf77_day,
    output logic [2:0] dcf77_day_of_week,
    output bcd2_t      dcf77_hour,
    output bcd2_t      dcf77_minute,
    output logic       locked,
    output logic       holdover,
    output logic [7:0] reject_count
);

    localparam logic [2:0]  CONFIRM_LAST = 3'(CONFIRM_FRAMES - 1);
    localparam logic [2:0]  CONFIRM_FULL = 3'(CONFIRM_FRAMES);
    localparam logic [7:0]  HOLD_LIMIT   = 8'(HOLDOVER_MIN);
    localparam logic [12:0] TICK_LAST    = 13'(TICKS_PER_MINUTE - 1);

    sync_state_t state;
    logic [2:0]  confirm;
    logic [12:0] tick_cnt;
    logic [7:0]  min_cnt;
    dcf77_time_t cur_frame, prev_frame, out_frame;
    logic        frame_ok, frame_next;
    logic        accept, fire, tick_wrap;

    assign cur_frame = '{
        year:   frame_year,
        month:  frame_month,
        day:    frame_day,
        dow:    frame_day_of_week,
        hour:   frame_hour,
        minute: frame_minute
    };

    dcf77_frame_check u_check (
        .cur        (cur_frame),
        .prev       (prev_frame),
        .frame_ok   (frame_ok),
        .frame_next (frame_next)
    );

    assign accept    = frame_valid && frame_ok && frame_next;
    assign fire      = accept && ((state == LOCKED) || (state == HOLDOVER) ||
                                  ((state == CANDIDATE) && (confirm == CONFIRM_LAST)));
    assign tick_wrap = clk_en && (tick_cnt == TICK_LAST);

    // Lock state machine with registered locked/holdover flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= UNLOCKED;
            confirm  <= 3'd0;
            locked   <= 1'b0;
            holdover <= 1'b0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (frame_valid && frame_ok) begin
                        confirm <= 3'd1;
                        state   <= CANDIDATE;
                    end
                end
                CANDIDATE: begin
                    if (frame_valid) begin
                        if (!frame_ok) begin
                            confirm <= 3'd0;
                            state   <= UNLOCKED;
                        end else if (!frame_next) begin
                            confirm <= 3'd1;
                        end else if (confirm == CONFIRM_LAST) begin
                            confirm <= CONFIRM_FULL;
                            state   <= LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            confirm <= confirm + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (!accept && (min_cnt == HOLD_LIMIT)) begin
                        state    <= HOLDOVER;
                        locked   <= 1'b0;
                        holdover <= 1'b1;
                    end
                end
                HOLDOVER: begin
                    if (accept) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        holdover <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Free-running minute timer; an accepted frame restarts the minute count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 13'd0;
            min_cnt  <= 8'd0;
        end else begin
            if (clk_en) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? 13'd0 : tick_cnt + 13'd1;
            end
            if (fire) begin
                min_cnt <= 8'd0;
            end else if (tick_wrap && (min_cnt != 8'hFF)) begin
                min_cnt <= min_cnt + 8'd1;
            end
        end
    end

    // Reference frame for the succession check; only in-range frames replace it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this frame store is reset to a legal time so the very first succession check has a defined reference.
        if (!rst_n) begin
            prev_frame <= RESET_TIME;
        end else if (frame_valid && frame_ok) begin
            prev_frame <= cur_frame;
        end
    end

    // Sync pulse and accepted-time hold: high until the clock's first enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_frame  <= RESET_TIME;
            dcf77_sync <= 1'b0;
        end else if (fire) begin
            out_frame  <= cur_frame;
            dcf77_sync <= 1'b1;
        end else if (dcf77_sync && clk_en) begin
            dcf77_sync <= 1'b0;
        end
    end

    assign dcf77_year        = out_frame.year;
    assign dcf77_month       = out_frame.month;
    assign dcf77_day         = out_frame.day;
    assign dcf77_day_of_week = out_frame.dow;
    assign dcf77_hour        = out_frame.hour;
    assign dcf77_minute      = out_frame.minute;

`ifdef DCF77_SYNC_STATS_EN
    logic       reject_evt;
    logic [7:0] reject_q;

    assign reject_evt = frame_valid && (!frame_ok || ((state != UNLOCKED) && !frame_next));

    // Saturating count of rejected frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_q <= 8'd0;
        end else if (reject_evt && (reject_q != 8'hFF)) begin
            reject_q <= reject_q + 8'd1;
        end
    end

    assign reject_count = reject_q;
`else
    assign reject_count = 8'd0;
`endif

endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// Directed bench for dcf77_sync_ctrl: lock sequence, reject paths,
// midnight rollover, back-to-back sync, holdover timeout and async reset.
module tb_dcf77_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en = 1'b0;
    logic       frame_valid;
    logic [7:0] frame_year, frame_month, frame_day, frame_hour, frame_minute;
    logic [2:0] frame_dow;
    logic       dcf77_sync;
    logic [7:0] dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute;
    logic [2:0] dcf77_dow;
    logic       locked, holdover;
    logic [7:0] reject_count;

    int n_compared   = 0;
    int n_mismatched = 0;

`ifdef DCF77_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dcf77_sync_ctrl #(
        .CONFIRM_FRAMES (2),
        .HOLDOVER_MIN   (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en            (clk_en),
        .frame_valid       (frame_valid),
        .frame_year        (frame_year),
        .frame_month       (frame_month),
        .frame_day         (frame_day),
        .frame_day_of_week (frame_dow),
        .frame_hour        (frame_hour),
        .frame_minute      (frame_minute),
        .dcf77_sync        (dcf77_sync),
        .dcf77_year        (dcf77_year),
        .dcf77_month       (dcf77_month),
        .dcf77_day         (dcf77_day),
        .dcf77_day_of_week (dcf77_dow),
        .dcf77_hour        (dcf77_hour),
        .dcf77_minute      (dcf77_minute),
        .locked            (locked),
        .holdover          (holdover),
        .reject_count      (reject_count)
    );

    initial forever #5 clk = ~clk;

    // clk_en every third cycle, changed on the falling edge.
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            div    = (div == 2) ? 0 : div + 1;
            clk_en = (div == 0);
        end
    end

    function automatic logic [7:0] exp_rej(input int n);
        if (!STATS) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // Called on a falling edge; returns on the next falling edge, after the capturing rising edge.
    task automatic send_frame(input logic [7:0] yr, input logic [7:0] mo, input logic [7:0] dy,
                              input logic [2:0] dw, input logic [7:0] hr, input logic [7:0] mn);
        frame_year   = yr;
        frame_month  = mo;
        frame_day    = dy;
        frame_dow    = dw;
        frame_hour   = hr;
        frame_minute = mn;
        frame_valid  = 1'b1;
        @(negedge clk);
        frame_valid  = 1'b0;
    endtask

    task automatic do_reset();
        frame_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_sync_drop(input string tag);
        int n = 0;
        while (dcf77_sync === 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        n_compared++;
        if (dcf77_sync !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s_sync_drop: dcf77_sync=%b after %0d cycles, want 0", tag, dcf77_sync, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_valid = 1'b0;
        frame_year = 8'h00; frame_month = 8'h01; frame_day = 8'h01;
        frame_dow = 3'd1; frame_hour = 8'h00; frame_minute = 8'h00;
        repeat (2) @(negedge clk);
        n_compared++; if ({dcf77_sync, locked, holdover} !== 3'b000) begin n_mismatched++; $display("FAIL reset_flags: sync/locked/holdover=%b want 000", {dcf77_sync, locked, holdover}); end
        n_compared++; if (reject_count !== 8'd0) begin n_mismatched++; $display("FAIL reset_rej: reject_count=%0d want 0", reject_count); end
        n_compared++; if ({dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute} !== 40'h00_01_01_00_00) begin n_mismatched++; $display("FAIL reset_time: got %h want 0001010000", {dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute}); end
        n_compared++; if (dcf77_dow !== 3'd1) begin n_mismatched++; $display("FAIL reset_dow: got %0d want 1", dcf77_dow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_lock();
        do_reset();
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h00);
        n_compared++; if ({dcf77_sync, locked} !== 2'b00) begin n_mismatched++; $display("FAIL lock_first: sync/locked=%b want 00", {dcf77_sync, locked}); end
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h01);
        n_compared++; if ({dcf77_sync, locked} !== 2'b11) begin n_mismatched++; $display("FAIL lock_second: sync/locked=%b want 11", {dcf77_sync, locked}); end
        n_compared++; if ({dcf77_hour, dcf77_minute} !== 16'h1201) begin n_mismatched++; $display("FAIL lock_time: got %h want 1201", {dcf77_hour, dcf77_minute}); end
        n_compared++; if ({dcf77_year, dcf77_month, dcf77_day, 5'(dcf77_dow)} !== {24'h24_02_29, 5'd4}) begin n_mismatched++; $display("FAIL lock_date: got %h %h %h %0d want 24 02 29 4", dcf77_year, dcf77_month, dcf77_day, dcf77_dow); end
        wait_sync_drop("lock");
        repeat (10) @(negedge clk);
        n_compared++; if ({dcf77_sync, locked, dcf77_minute} !== {2'b01, 8'h01}) begin n_mismatched++; $display("FAIL lock_hold: sync/locked=%b%b minute=%h want 01 01", dcf77_sync, locked, dcf77_minute); end
    endtask

    task automatic test_candidate_reject();
        do_reset();
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h10, 8'h05);
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h10, 8'h07);
        n_compared++; if ({dcf77_sync, locked, holdover} !== 3'b000) begin n_mismatched++; $display("FAIL cand_gap: sync/locked/holdover=%b want 000", {dcf77_sync, locked, holdover}); end
        n_compared++; if (reject_count !== exp_rej(1)) begin n_mismatched++; $display("FAIL cand_rej: reject_count=%0d want %0d", reject_count, exp_rej(1)); end
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h10, 8'h08);
        n_compared++; if ({dcf77_sync, locked, dcf77_minute} !== {2'b11, 8'h08}) begin n_mismatched++; $display("FAIL cand_lock: sync/locked=%b%b minute=%h want 11 08", dcf77_sync, locked, dcf77_minute); end
        wait_sync_drop("cand");
    endtask

    task automatic test_locked_reject();
        do_reset();
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h00);
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h01);
        wait_sync_drop("lrej_lock");
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h6A);
        n_compared++; if ({dcf77_sync, locked} !== 2'b01) begin n_mismatched++; $display("FAIL lrej_bad: sync/locked=%b want 01", {dcf77_sync, locked}); end
        n_compared++; if (reject_count !== exp_rej(1)) begin n_mismatched++; $display("FAIL lrej_bad_cnt: reject_count=%0d want %0d", reject_count, exp_rej(1)); end
        n_compared++; if (dcf77_minute !== 8'h01) begin n_mismatched++; $display("FAIL lrej_bad_out: minute=%h want 01", dcf77_minute); end
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h02);
        n_compared++; if ({dcf77_sync, dcf77_minute} !== {1'b1, 8'h02}) begin n_mismatched++; $display("FAIL lrej_resume: sync=%b minute=%h want 1 02", dcf77_sync, dcf77_minute); end
        wait_sync_drop("lrej_resume");
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h05);
        n_compared++; if ({dcf77_sync, locked, dcf77_minute} !== {2'b01, 8'h02}) begin n_mismatched++; $display("FAIL lrej_jump: sync/locked=%b%b minute=%h want 01 02", dcf77_sync, locked, dcf77_minute); end
        n_compared++; if (reject_count !== exp_rej(2)) begin n_mismatched++; $display("FAIL lrej_jump_cnt: reject_count=%0d want %0d", reject_count, exp_rej(2)); end
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h06);
        n_compared++; if ({dcf77_sync, dcf77_minute} !== {1'b1, 8'h06}) begin n_mismatched++; $display("FAIL lrej_follow: sync=%b minute=%h want 1 06", dcf77_sync, dcf77_minute); end
        wait_sync_drop("lrej_follow");
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h23, 8'h12, 8'h31, 3'd7, 8'h23, 8'h58);
        send_frame(8'h23, 8'h12, 8'h31, 3'd7, 8'h23, 8'h59);
        n_compared++; if ({dcf77_sync, locked, dcf77_hour, dcf77_minute} !== {2'b11, 16'h2359}) begin n_mismatched++; $display("FAIL b2b_lock: sync/locked=%b%b time=%h%h want 11 2359", dcf77_sync, locked, dcf77_hour, dcf77_minute); end
        send_frame(8'h24, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00);
        n_compared++; if (dcf77_sync !== 1'b1) begin n_mismatched++; $display("FAIL b2b_extend: sync=%b want 1", dcf77_sync); end
        n_compared++; if ({dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute} !== 40'h24_01_01_00_00) begin n_mismatched++; $display("FAIL b2b_midnight: got %h want 2401010000", {dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute}); end
        n_compared++; if (dcf77_dow !== 3'd1) begin n_mismatched++; $display("FAIL b2b_dow: got %0d want 1", dcf77_dow); end
        wait_sync_drop("b2b");
        send_frame(8'h24, 8'h01, 8'h01, 3'd1, 8'h02, 8'h01);
        n_compared++; if ({dcf77_sync, dcf77_hour} !== {1'b0, 8'h00}) begin n_mismatched++; $display("FAIL b2b_badhour: sync=%b hour=%h want 0 00", dcf77_sync, dcf77_hour); end
    endtask

    task automatic count_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (clk_en !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_holdover();
        do_reset();
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h00);
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h01);
        count_ticks(5000);
        n_compared++; if ({locked, holdover} !== 2'b10) begin n_mismatched++; $display("FAIL hold_early: locked/holdover=%b want 10", {locked, holdover}); end
        count_ticks(7000);
        @(negedge clk);
        n_compared++; if ({locked, holdover} !== 2'b01) begin n_mismatched++; $display("FAIL hold_enter: locked/holdover=%b want 01", {locked, holdover}); end
        count_ticks(6000);
        n_compared++; if ({locked, holdover} !== 2'b01) begin n_mismatched++; $display("FAIL hold_stay: locked/holdover=%b want 01", {locked, holdover}); end
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h02);
        n_compared++; if ({dcf77_sync, locked, holdover, dcf77_minute} !== {3'b110, 8'h02}) begin n_mismatched++; $display("FAIL hold_relock: sync/locked/holdover=%b%b%b minute=%h want 110 02", dcf77_sync, locked, holdover, dcf77_minute); end
        wait_sync_drop("hold");
    endtask

    task automatic test_async_reset();
        do_reset();
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h00);
        send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h01);
        n_compared++; if (dcf77_sync !== 1'b1) begin n_mismatched++; $display("FAIL arst_pre: sync=%b want 1", dcf77_sync); end
        #1 rst_n = 1'b0;
        #1;
        n_compared++; if ({dcf77_sync, locked, holdover, dcf77_minute} !== {3'b000, 8'h00}) begin n_mismatched++; $display("FAIL arst_now: sync/locked/holdover=%b%b%b minute=%h want 000 00", dcf77_sync, locked, holdover, dcf77_minute); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 300; i++) send_frame(8'h24, 8'h02, 8'h29, 3'd4, 8'h12, 8'h6A);
        n_compared++; if (reject_count !== exp_rej(300)) begin n_mismatched++; $display("FAIL arst_rej_sat: reject_count=%0d want %0d", reject_count, exp_rej(300)); end
        n_compared++; if ({dcf77_sync, locked} !== 2'b00) begin n_mismatched++; $display("FAIL arst_bad_lock: sync/locked=%b want 00", {dcf77_sync, locked}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_lock();
        test_candidate_reject();
        test_locked_reject();
        test_back_to_back();
        test_holdover();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
